// File: rtl/hdlverifier_jtag_dr_shifter.sv
// hdlverifier_jtag_dr_shifter
//
// Data-register shifter that sits behind the virtual JTAG wrapper. Everything
// runs on tck. Each complete DR scan of DATA_WIDTH bits becomes one parallel
// receive word. During the same scan, one pending transmit word is shifted
// out LSB first.
//
// Ports
//   clk          tck from the wrapper; every register uses its rising edge
//   reset_n      synchronous active-low reset
//   sync_clr     wrapper jtag_reset; synchronous soft clear, same effect as reset
//   tdi          serial data from the host
//   capture_dr   virtual CDR strobe
//   shift_dr     virtual SDR strobe
//   update_dr    virtual UDR strobe
//   tdo          serial data to the host (shift register bit 0)
//   rx_data      last received word
//   rx_valid     rx_data holds an unconsumed word
//   rx_ready     consumer accepts rx_data when rx_valid is also high
//   tx_data      word to send on the next scan
//   tx_valid     tx_data is offered
//   tx_ready     transmit buffer is empty
//   frame_error  one-cycle pulse on a bad update (wrong length or no capture)
//   rx_overflow  sticky; a completed scan was dropped
//
// state | meaning
// IDLE  | no scan in progress; shift and update strobes are not part of a scan
// CAPT  | capture done, waiting for the first shift
// SHIFT | shifting payload bits
module hdlverifier_jtag_dr_shifter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sync_clr,
  input  logic                  tdi,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic                  tdo,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  frame_error,
  output logic                  rx_overflow
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  clr;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_full_q, tx_full_d;
  logic                  tx_armed_q, tx_armed_d;
  logic                  frame_error_q, frame_error_d;
  logic                  rx_overflow_q, rx_overflow_d;

  // Decoded strobes. Priority is capture > update > shift.
  logic do_capt;
  logic do_shift;
  logic upd_good;
  logic upd_bad;

  // reset_n and sync_clr have identical effect
  assign clr = !reset_n || sync_clr;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (capture_dr) begin
      state_d = CAPT;
    end else if (update_dr) begin
      state_d = IDLE;
    end else if (shift_dr && state_q == CAPT) begin
      state_d = SHIFT;
    end
  end

  // FSM: outputs (strobe qualification)
  always_comb begin
    do_capt  = capture_dr;
    do_shift = 1'b0;
    upd_good = 1'b0;
    upd_bad  = 1'b0;
    if (!capture_dr) begin
      if (update_dr) begin
        if (state_q != IDLE && cnt_q == CNT_FULL) begin
          upd_good = 1'b1;
        end else begin
          upd_bad = 1'b1;
        end
      end else if (shift_dr && state_q != IDLE) begin
        do_shift = 1'b1;
      end
    end
  end

  // Datapath next state
  always_comb begin
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    tx_armed_d    = tx_armed_q;
    rx_overflow_d = rx_overflow_q;
    frame_error_d = upd_bad;

    if (do_capt) begin
      sr_d       = tx_full_q ? tx_buf_q : '0;
      tx_armed_d = tx_full_q;
      cnt_d      = '0;
    end else if (do_shift) begin
      sr_d = {tdi, sr_q[DATA_WIDTH-1:1]};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // consumer handshake first, so a same-cycle write below overrides the clear
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (upd_good) begin
      if (rx_valid_q && !rx_ready) begin
        rx_overflow_d = 1'b1;
      end else begin
        rx_data_d  = sr_q;
        rx_valid_d = 1'b1;
      end
      if (tx_armed_q) begin
        tx_full_d  = 1'b0;
        tx_armed_d = 1'b0;
      end
    end

    // A load is only possible while the buffer is empty, which never overlaps
    // a release (release requires the buffer to be full). The capture above
    // already sampled tx_full_q, so a load alongside a capture waits a scan.
    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q          <= '0;
      cnt_q         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_armed_q    <= 1'b0;
      frame_error_q <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      tx_armed_q    <= tx_armed_d;
      frame_error_q <= frame_error_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  // Driven straight from the register so the host's falling-edge sample is stable
  assign tdo         = sr_q[0];
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = !tx_full_q;
  assign frame_error = frame_error_q;
  assign rx_overflow = rx_overflow_q;

endmodule

// File: tb/tb_hdlverifier_jtag_dr_shifter.sv
module tb_hdlverifier_jtag_dr_shifter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sync_clr;
  logic         tdi;
  logic         capture_dr;
  logic         shift_dr;
  logic         update_dr;
  logic         tdo;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         frame_error;
  logic         rx_overflow;

  int n_vec = 0;
  int n_mis = 0;

  // scoreboard queues and a small model of the buffers
  logic [W-1:0] rx_q[$];
  logic         tdo_q[$];
  logic         tx_full_m;
  logic [W-1:0] tx_word_m;
  logic         ovf_m;

  always #5 clk = ~clk;

  hdlverifier_jtag_dr_shifter #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sync_clr    (sync_clr),
    .tdi         (tdi),
    .capture_dr  (capture_dr),
    .shift_dr    (shift_dr),
    .update_dr   (update_dr),
    .tdo         (tdo),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frame_error (frame_error),
    .rx_overflow (rx_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    rx_q.delete();
    tdo_q.delete();
    tx_full_m = 1'b0;
    tx_word_m = '0;
    ovf_m     = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tdo"},         tdo,         1'b0);
    chk({tag, "_rx_valid"},    rx_valid,    1'b0);
    chk({tag, "_rx_data"},     rx_data,     '0);
    chk({tag, "_tx_ready"},    tx_ready,    1'b1);
    chk({tag, "_frame_error"}, frame_error, 1'b0);
    chk({tag, "_rx_overflow"}, rx_overflow, 1'b0);
  endtask

  task automatic offer_tx(input logic [W-1:0] word);
    chk("tx_ready_pre", tx_ready, 1'b1);
    tx_data  = word;
    tx_valid = 1'b1;
    tick();
    tx_valid  = 1'b0;
    tx_full_m = 1'b1;
    tx_word_m = word;
    chk("tx_ready_fall", tx_ready, 1'b0);
  endtask

  // One scan: capture, nbits shifts of word (zeros past W), update.
  // rx_ready is held low throughout.
  task automatic scan(input logic [W-1:0] word, input int nbits);
    logic [W-1:0] sent;
    logic         armed;
    logic         b;
    armed = tx_full_m;
    sent  = tx_full_m ? tx_word_m : '0;
    for (int i = 0; i < nbits; i++) begin
      if (i < W) tdo_q.push_back(sent[i]);
      else       tdo_q.push_back(word[i-W]);
    end
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i < W) tdi = word[i];
      else       tdi = 1'b0;
      shift_dr = 1'b1;
      b = tdo_q.pop_front();
      chk($sformatf("tdo_bit%0d", i), tdo, b);
      tick();
    end
    shift_dr  = 1'b0;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    if (nbits == W) begin
      if (rx_q.size() > 0) ovf_m = 1'b1;
      else                 rx_q.push_back(word);
      if (armed) tx_full_m = 1'b0;
    end
    chk("frame_error", frame_error, nbits != W);
    chk("rx_valid",    rx_valid,    rx_q.size() > 0);
    chk("rx_overflow", rx_overflow, ovf_m);
    chk("tx_ready",    tx_ready,    !tx_full_m);
    tick();
    chk("frame_error_pulse", frame_error, 1'b0);
  endtask

  task automatic consume();
    logic [W-1:0] exp;
    chk("rx_valid_pre", rx_valid, 1'b1);
    if (rx_q.size() == 0) begin
      chk("rx_q_nonempty", 1'b0, 1'b1);
      exp = '0;
    end else begin
      exp = rx_q.pop_front();
    end
    chk("rx_data", rx_data, exp);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_valid_post", rx_valid, 1'b0);
    chk("rx_data_hold",  rx_data,  exp);
  endtask

  task automatic clear_mid_scan(input bit use_sync);
    offer_tx(32'h1122_3344);
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tdi      = i[0];
      shift_dr = 1'b1;
      tick();
    end
    shift_dr = 1'b0;
    if (use_sync) sync_clr = 1'b1;
    else          reset_n  = 1'b0;
    tick();
    sync_clr = 1'b0;
    reset_n  = 1'b1;
    model_clear();
    check_idle(use_sync ? "sync_clr" : "reset_n");
    scan(32'h5A5A_C3C3 ^ {31'd0, use_sync}, W);
    consume();
  endtask

  initial begin
    reset_n    = 1'b0;
    sync_clr   = 1'b0;
    tdi        = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    rx_ready   = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    model_clear();
    tick();
    tick();
    reset_n = 1'b1;
    check_idle("reset");

    // normal receive
    scan(32'hA5A5_1234, W);
    consume();

    // normal transmit
    offer_tx(32'hDEAD_BEEF);
    scan(32'h1357_9BDF, W);
    consume();

    // short scan: frame error, tx word kept and resent
    offer_tx(32'hCAFE_F00D);
    scan(32'h0000_FFFF, W - 1);
    scan(32'h0F0F_0F0F, W);
    consume();

    // overflow
    scan(32'h0000_0001, W);
    scan(32'h0000_0002, W);
    consume();
    chk("rx_overflow_sticky", rx_overflow, 1'b1);

    // long scan saturates the counter
    scan(32'h89AB_CDEF, 40);

    // update with no capture
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    chk("idle_update_fe", frame_error, 1'b1);
    chk("idle_update_rx", rx_valid, 1'b0);
    tick();
    chk("idle_update_fe_pulse", frame_error, 1'b0);

    // clears in the middle of a scan
    clear_mid_scan(1'b1);
    clear_mid_scan(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/hdlverifier_jtag_dr_shifter.md
Name: hdlverifier_jtag_dr_shifter

Overview:
- Bidirectional data-register shifter directly downstream of the virtual JTAG vendor IP wrapper.
- Consumes the wrapper's tdi / capture_dr / shift_dr / update_dr / jtag_reset strobes and drives its tdo, all in the tck domain (clk is tck).
- Converts each complete DR scan of DATA_WIDTH bits into one parallel receive word with a valid/ready handshake.
- Simultaneously shifts out one pending transmit word, LSB first, toward the host (MATLAB/hdlverifier).

Parameters:
- DATA_WIDTH, 32, DR payload length in bits; legal 8..64. Counter width is derived internally as clog2(DATA_WIDTH+2).

Ports:
- clk  input  1  tck from the virtual JTAG wrapper; all logic is on its rising edge
- reset_n  input  1  reset, synchronous, active-low
- sync_clr  input  1  jtag_reset (ir[0]) from the wrapper; synchronous soft clear
- tdi  input  1  serial data from the host
- capture_dr  input  1  virtual CDR state
- shift_dr  input  1  virtual SDR state
- update_dr  input  1  virtual UDR state
- tdo  output  1  serial data to the host, equal to shift register bit 0
- rx_data  output  DATA_WIDTH  received word
- rx_valid  output  1  rx_data holds an unconsumed word
- rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high
- tx_data  input  DATA_WIDTH  word to send on the next scan
- tx_valid  input  1  tx_data offered
- tx_ready  output  1  transmit buffer empty; the word is taken when tx_valid and tx_ready are both high
- frame_error  output  1  one-cycle pulse: update arrived with a bit count other than DATA_WIDTH, or without a capture
- rx_overflow  output  1  sticky; a completed scan was dropped because rx_valid was still pending

Behaviour:
- Reset (reset_n=0 at posedge) or sync_clr=1 (same effect, reset_n has priority):
  - FSM goes to IDLE.
  - Shift register, counter, rx_data, tx buffer go to 0.
  - rx_valid=0, tx_ready=1, frame_error=0, rx_overflow=0.
  - tdo=0.
- FSM states and transitions:
  - IDLE -> CAPT on capture_dr.
  - CAPT -> SHIFT on the first shift_dr.
  - SHIFT or CAPT -> IDLE on update_dr.
  - capture_dr in any state restarts at CAPT.
  - Strobe priority when several are high in one cycle: capture_dr > update_dr > shift_dr.
- Capture cycle:
  - Shift register loads the tx buffer if it is full, else all zeros.
  - tx_armed is set equal to "tx buffer full".
  - Bit counter clears to 0.
- Shift cycle (shift_dr=1, state CAPT or SHIFT):
  - Shift register becomes {tdi, sr[DATA_WIDTH-1:1]}, i.e. LSB exits first.
  - Counter increments, saturating at DATA_WIDTH+1.
  - tdo = sr[0] combinationally from the register, so it is stable for the host's falling-edge sample.
  - shift_dr in IDLE is ignored: no shift, no count.
- Update cycle, state CAPT or SHIFT:
  - If count == DATA_WIDTH:
    - If rx_valid=1 and rx_ready=0 in this cycle: word dropped, rx_overflow set.
    - Otherwise: rx_data <= shift register, rx_valid <= 1.
    - If tx_armed: tx buffer freed, so tx_ready is 1 from the next cycle.
  - If count != DATA_WIDTH: frame_error pulses for one cycle; rx and tx state are unchanged, and the tx word is resent on the next scan.
- update_dr in IDLE: frame_error pulses; nothing else changes.
- rx handshake:
  - rx_valid clears the cycle after rx_valid and rx_ready are both high.
  - A simultaneous accept and new-word write leaves rx_valid=1 with the new data; no overflow.
  - rx_data holds its value while rx_valid=0.
- tx handshake:
  - tx_ready = not tx buffer full.
  - The buffer loads on tx_valid and tx_ready both high; the word is visible to the next capture.
  - A load in the same cycle as capture_dr is not seen by that capture; it goes to the following scan.
- rx_overflow clears only on reset_n or sync_clr.
- Latency:
  - rx_valid rises 1 cycle after the update cycle.
  - The tx word appears on tdo 1 cycle after capture.

Test Plan:
- Normal rx: reset; capture, shift 32 bits of 0xA5A5_1234 LSB first, update, with rx_ready=0 -> next cycle rx_valid=1 and rx_data=0xA5A51234; set rx_ready=1 -> rx_valid=0 one cycle later.
- Normal tx: offer tx_data=0xDEADBEEF with tx_valid -> tx_ready falls; run a full scan -> tdo emits 1,1,1,1,0,1,1,1… (0xDEADBEEF LSB first); after update, tx_ready=1.
- Short scan: shift 31 bits then update -> frame_error is a single-cycle pulse; rx_valid stays 0; tx_ready stays 0; the next full scan resends the same tx word.
- Overflow: two complete scans (0x1, 0x2) with rx_ready held 0 -> rx_data=0x1 and rx_overflow=1; then rx_ready=1 -> rx_valid=0 and rx_overflow stays 1.
- Long scan: shift 40 bits then update -> counter saturates, frame_error pulses, no rx_valid.
- Clear mid-scan: sync_clr=1 after 10 shifts -> all outputs return to reset values; a subsequent full scan completes normally. Repeat the same sequence using reset_n=0 -> identical result.
